// File: rtl/poly_tone_generator_if.sv
// poly_tone_generator_if
//   Configuration write port of the multi-channel tone generator.
//   A write is transferred on a clock edge where cfg_valid && cfg_ready.
//
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  target channel can take a write
//   cfg_ch     master->slave  target channel (values >= NUM_CH are dropped)
//   cfg_en     master->slave  channel enable
//   cfg_note   master->slave  0..6 = C3..B3, 7 = rest
//   cfg_oct    master->slave  octave shift 0..3
//   cfg_mode   master->slave  duty mode
//   cfg_vol    master->slave  attenuation (right shift of full scale)
interface poly_tone_generator_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_ch;
  logic       cfg_en;
  logic [2:0] cfg_note;
  logic [1:0] cfg_oct;
  logic [1:0] cfg_mode;
  logic [1:0] cfg_vol;

  modport master (
    output cfg_valid, cfg_ch, cfg_en, cfg_note, cfg_oct, cfg_mode, cfg_vol,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_en, cfg_note, cfg_oct, cfg_mode, cfg_vol,
    output cfg_ready
  );
endinterface

// File: rtl/poly_tone_generator.sv
// poly_tone_generator
//   NUM_CH independent square/pulse tone channels summed into one registered
//   sample word. Each channel plays a note from a 7-entry half-period table,
//   shifted by an octave, at a selectable duty and volume. New settings are
//   held in shadow registers and take effect only at a period boundary (or
//   at once if the channel is silent), so no truncated pulse is produced.
//
//   Build option: define WAVE_GEN_DUTY_EN to enable the 25% / 12.5% pulse
//   modes; without it every mode plays a 50% square.
//
// Ports
//   clk     system clock
//   rst     asynchronous active-high reset
//   ce_i    sample tick; period counters advance only when high
//   cfg     configuration write port (slave side)
//   word_o  mixed sample, sum of all channel levels
//   busy_o  per-channel flag: a written update is waiting to be applied
module poly_tone_generator #(
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 12,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce_i,
  poly_tone_generator_if.slave         cfg,
  output logic [OUT_W+((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] word_o,
  output logic [NUM_CH-1:0]            busy_o
);

  localparam int WORD_W = OUT_W + ((NUM_CH > 1) ? $clog2(NUM_CH) : 1);
  localparam logic [OUT_W-1:0] FULL = {OUT_W{1'b1}};

  // Base half-periods in ce ticks, C3..B3. Rest returns 0 but is never used
  // because a resting channel is held inactive.
  function automatic logic [7:0] half_base(input logic [2:0] note);
    case (note)
      3'd0:    half_base = 8'd166;
      3'd1:    half_base = 8'd148;
      3'd2:    half_base = 8'd132;
      3'd3:    half_base = 8'd124;
      3'd4:    half_base = 8'd111;
      3'd5:    half_base = 8'd99;
      3'd6:    half_base = 8'd88;
      default: half_base = 8'd0;
    endcase
  endfunction

  logic [7:0]       busy_pad;
  logic             accept;
  logic [OUT_W-1:0] level_w [NUM_CH];
  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] word_q;

  // Padding to 8 entries makes out-of-range channels always ready, so such
  // writes complete in one cycle and are simply ignored.
  assign busy_pad      = 8'(busy_o);
  assign cfg.cfg_ready = ~busy_pad[cfg.cfg_ch];
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic             act_en_q, shd_en_q;
    logic [2:0]       act_note_q, shd_note_q;
    logic [1:0]       act_oct_q, shd_oct_q;
    logic [1:0]       act_mode_q, shd_mode_q;
    logic [1:0]       act_vol_q, shd_vol_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] level_q, level_d;
    logic             wr_sel, active, wrap, apply;
    logic [CNT_W-1:0] per, thr;

    assign wr_sel = accept && (cfg.cfg_ch == 3'(gi));
    assign active = act_en_q && (act_note_q != 3'd7);
    assign per    = CNT_W'(half_base(act_note_q) >> act_oct_q);
    assign wrap   = active && ce_i && (cnt_q == (per << 1) - 1'b1);
    // busy_q is still 0 on the accept edge itself, so a write landing on a
    // wrap edge naturally waits for the next wrap.
    assign apply  = busy_q && (wrap || !active);

    always_comb begin
      thr = per;
`ifdef WAVE_GEN_DUTY_EN
      case (act_mode_q)
        2'd1:    thr = per >> 1;
        2'd2:    thr = per >> 2;
        default: thr = per;
      endcase
`else
      // Duty shaping removed: every stored mode maps to the 50% square.
      case (act_mode_q)
        2'd1:    thr = per;
        default: thr = per;
      endcase
`endif
    end

    always_comb begin
      cnt_d = cnt_q;
      if (apply || !active || wrap) begin
        cnt_d = '0;
      end else if (ce_i) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    assign level_d = (active && (cnt_q < thr)) ? (FULL >> act_vol_q) : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        act_en_q   <= 1'b0;
        act_note_q <= '0;
        act_oct_q  <= '0;
        act_mode_q <= '0;
        act_vol_q  <= '0;
        shd_en_q   <= 1'b0;
        shd_note_q <= '0;
        shd_oct_q  <= '0;
        shd_mode_q <= '0;
        shd_vol_q  <= '0;
        busy_q     <= 1'b0;
        cnt_q      <= '0;
        level_q    <= '0;
      end else begin
        if (wr_sel) begin
          shd_en_q   <= cfg.cfg_en;
          shd_note_q <= cfg.cfg_note;
          shd_oct_q  <= cfg.cfg_oct;
          shd_mode_q <= cfg.cfg_mode;
          shd_vol_q  <= cfg.cfg_vol;
        end
        // wr_sel and apply never coincide: a busy channel is not ready.
        if (wr_sel) begin
          busy_q <= 1'b1;
        end else if (apply) begin
          busy_q <= 1'b0;
        end
        if (apply) begin
          act_en_q   <= shd_en_q;
          act_note_q <= shd_note_q;
          act_oct_q  <= shd_oct_q;
          act_mode_q <= shd_mode_q;
          act_vol_q  <= shd_vol_q;
        end
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign busy_o[gi]  = busy_q;
    assign level_w[gi] = level_q;
  end

  always_comb begin
    word_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      word_d = word_d + WORD_W'(level_w[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: tb/tb_poly_tone_generator.sv
module tb_poly_tone_generator;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [12:0] word;
  logic [1:0]  busy;
  int          vectors = 0;
  int          miscompares = 0;

  poly_tone_generator_if cfg_bus();

  poly_tone_generator #(.NUM_CH(2), .OUT_W(12), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce_i   (ce),
    .cfg    (cfg_bus),
    .word_o (word),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Presents one write and holds it until accepted; returns 1 ns after the
  // accept edge. ok=0 if the port never became ready.
  task automatic cfg_write(input logic [2:0] ch, input logic en, input logic [2:0] note,
                           input logic [1:0] oct, input logic [1:0] mode,
                           input logic [1:0] vol, output logic ok);
    int i;
    cfg_bus.cfg_ch    = ch;
    cfg_bus.cfg_en    = en;
    cfg_bus.cfg_note  = note;
    cfg_bus.cfg_oct   = oct;
    cfg_bus.cfg_mode  = mode;
    cfg_bus.cfg_vol   = vol;
    cfg_bus.cfg_valid = 1'b1;
    #1;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 1000) begin
      if (cfg_bus.cfg_ready) ok = 1'b1;
      @(posedge clk); #1;
      i++;
    end
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b1;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = 3'd0; cfg_bus.cfg_en = 1'b0;
    cfg_bus.cfg_note = 3'd0; cfg_bus.cfg_oct = 2'd0; cfg_bus.cfg_mode = 2'd0;
    cfg_bus.cfg_vol = 2'd0;
    #1 rst = 1'b1;
    #1;
    vectors++; if (word !== 13'd0) begin miscompares++; $display("FAIL reset_word got=%0d exp=0", word); end
    vectors++; if (busy !== 2'b00) begin miscompares++; $display("FAIL reset_busy got=%b exp=00", busy); end
    vectors++; if (cfg_bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", cfg_bus.cfg_ready); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_square();
    logic ok;
    logic [12:0] exp;
    do_reset();
    cfg_write(3'd0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL square_accept timeout"); end
    vectors++; if (busy !== 2'b01) begin miscompares++; $display("FAIL square_busy_set got=%b exp=01", busy); end
    for (int m = 1; m <= 667; m++) begin
      @(posedge clk); #1;
      exp = (m < 3) ? 13'd0 : ((((m - 3) % 332) < 166) ? 13'd4095 : 13'd0);
      vectors++; if (word !== exp) begin miscompares++; $display("FAIL square_word m=%0d got=%0d exp=%0d", m, word, exp); end
      vectors++; if (busy !== 2'b00) begin miscompares++; $display("FAIL square_busy m=%0d got=%b exp=00", m, busy); end
    end
  endtask

  task automatic test_oct_vol();
    logic ok;
    logic [12:0] exp;
    do_reset();
    cfg_write(3'd0, 1'b1, 3'd5, 2'd2, 2'd0, 2'd1, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL octvol_accept timeout"); end
    for (int m = 1; m <= 99; m++) begin
      @(posedge clk); #1;
      exp = (m < 3) ? 13'd0 : ((((m - 3) % 48) < 24) ? 13'd2047 : 13'd0);
      vectors++; if (word !== exp) begin miscompares++; $display("FAIL octvol_word m=%0d got=%0d exp=%0d", m, word, exp); end
    end
  endtask

  task automatic test_deferred();
    logic ok;
    logic [12:0] exp;
    logic exp_busy;
    do_reset();
    cfg_write(3'd0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL deferred_accept timeout"); end
    for (int m = 1; m <= 598; m++) begin
      @(posedge clk); #1;
      if (m < 3)        exp = 13'd0;
      else if (m <= 334) exp = (((m - 3) % 332) < 166) ? 13'd4095 : 13'd0;
      else               exp = (((m - 335) % 176) < 88) ? 13'd4095 : 13'd0;
      exp_busy = (m >= 101) && (m <= 332);
      vectors++; if (word !== exp) begin miscompares++; $display("FAIL deferred_word m=%0d got=%0d exp=%0d", m, word, exp); end
      vectors++; if (busy[0] !== exp_busy) begin miscompares++; $display("FAIL deferred_busy m=%0d got=%b exp=%b", m, busy[0], exp_busy); end
      vectors++; if (cfg_bus.cfg_ready !== !exp_busy) begin miscompares++; $display("FAIL deferred_ready m=%0d got=%b exp=%b", m, cfg_bus.cfg_ready, !exp_busy); end
      if (m == 100) begin
        cfg_bus.cfg_note  = 3'd6;
        cfg_bus.cfg_valid = 1'b1;
      end
      if (m == 101) cfg_bus.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_mix_duty();
    logic ok0, ok1;
    logic [12:0] exp;
    int k;
    do_reset();
    ce = 1'b0;
    cfg_write(3'd0, 1'b1, 3'd0, 2'd0, 2'd1, 2'd0, ok0);
    cfg_write(3'd1, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, ok1);
    vectors++; if ((ok0 & ok1) !== 1'b1) begin miscompares++; $display("FAIL mix_accept got=%b%b exp=11", ok0, ok1); end
    // counters frozen at 0: both channels hold their high level
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      exp = (j == 1) ? 13'd0 : ((j == 2) ? 13'd4095 : 13'd8190);
      vectors++; if (word !== exp) begin miscompares++; $display("FAIL mix_frozen j=%0d got=%0d exp=%0d", j, word, exp); end
    end
    ce = 1'b1;
    for (int n = 1; n <= 666; n++) begin
      @(posedge clk); #1;
      k = (n < 2) ? 0 : ((n - 2) % 332);
`ifdef WAVE_GEN_DUTY_EN
      exp = ((k < 83) ? 13'd4095 : 13'd0) + ((k < 166) ? 13'd4095 : 13'd0);
`else
      exp = (k < 166) ? 13'd8190 : 13'd0;
`endif
      vectors++; if (word !== exp) begin miscompares++; $display("FAIL mix_word n=%0d got=%0d exp=%0d", n, word, exp); end
    end
  endtask

  task automatic test_rest_oor();
    logic ok;
    logic [12:0] exp;
    do_reset();
    cfg_write(3'd1, 1'b1, 3'd7, 2'd0, 2'd0, 2'd0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rest_accept timeout"); end
    vectors++; if (busy !== 2'b10) begin miscompares++; $display("FAIL rest_busy_set got=%b exp=10", busy); end
    for (int m = 1; m <= 3; m++) begin
      @(posedge clk); #1;
      vectors++; if (busy !== 2'b00) begin miscompares++; $display("FAIL rest_busy m=%0d got=%b exp=00", m, busy); end
      vectors++; if (word !== 13'd0) begin miscompares++; $display("FAIL rest_word m=%0d got=%0d exp=0", m, word); end
    end
    // active note is rest, so this write applies on the next edge
    cfg_write(3'd1, 1'b1, 3'd2, 2'd0, 2'd0, 2'd0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rest_play_accept timeout"); end
    for (int m = 1; m <= 300; m++) begin
      @(posedge clk); #1;
      exp = (m < 3) ? 13'd0 : ((((m - 3) % 264) < 132) ? 13'd4095 : 13'd0);
      vectors++; if (word !== exp) begin miscompares++; $display("FAIL oor_word m=%0d got=%0d exp=%0d", m, word, exp); end
      vectors++; if (busy !== 2'b00) begin miscompares++; $display("FAIL oor_busy m=%0d got=%b exp=00", m, busy); end
      if (m == 50) begin
        cfg_bus.cfg_ch    = 3'd5;
        cfg_bus.cfg_en    = 1'b0;
        cfg_bus.cfg_note  = 3'd6;
        cfg_bus.cfg_valid = 1'b1;
        #1;
        vectors++; if (cfg_bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL oor_ready got=%b exp=1", cfg_bus.cfg_ready); end
      end
      if (m == 51) cfg_bus.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    do_reset();
    cfg_write(3'd0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, ok);
    repeat (20) @(posedge clk);
    #1;
    cfg_write(3'd0, 1'b1, 3'd6, 2'd0, 2'd0, 2'd0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL midrst_accept timeout"); end
    vectors++; if (busy !== 2'b01) begin miscompares++; $display("FAIL midrst_busy_pre got=%b exp=01", busy); end
    vectors++; if (word !== 13'd4095) begin miscompares++; $display("FAIL midrst_word_pre got=%0d exp=4095", word); end
    rst = 1'b1;
    #1;
    vectors++; if (word !== 13'd0) begin miscompares++; $display("FAIL midrst_word got=%0d exp=0", word); end
    vectors++; if (busy !== 2'b00) begin miscompares++; $display("FAIL midrst_busy got=%b exp=00", busy); end
    vectors++; if (cfg_bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got=%b exp=1", cfg_bus.cfg_ready); end
    rst = 1'b0;
    for (int m = 1; m <= 400; m++) begin
      @(posedge clk); #1;
      vectors++; if (word !== 13'd0) begin miscompares++; $display("FAIL midrst_after m=%0d got=%0d exp=0", m, word); end
      vectors++; if (busy !== 2'b00) begin miscompares++; $display("FAIL midrst_after_busy m=%0d got=%b exp=00", m, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_oct_vol();
    test_deferred();
    test_mix_duty();
    test_rest_oor();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/poly_tone_generator.md
# poly_tone_generator

Multi-channel tone generator. It is the successor to the single-channel square-wave note generator in the audio path. It drives NUM_CH independent channels from a 7-note table with an octave shift, per-channel duty mode and volume. Channel settings are updated glitch-free at period boundaries through a valid/ready config port. The channels are summed into one registered word for the DAC/PWM stage.

## Interface
Parameters:
- NUM_CH, 2: number of channels (1..8).
- OUT_W, 12: per-channel full-scale sample width.
- CNT_W, 16: period counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  sample tick enable; counters advance only when ce=1.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config port can accept a write.
- cfg_ch  in  3  target channel.
- cfg_en  in  1  channel enable.
- cfg_note  in  3  note 0..6 = C3,D3,E3,F3,G3,A3,B3; 7 = rest.
- cfg_oct  in  2  octave shift 0..3.
- cfg_mode  in  2  0 = square 50%, 1 = pulse 25%, 2 = pulse 12.5%, 3 = square 50%.
- cfg_vol  in  2  attenuation, as a right shift of full scale.
- word  out  OUT_W+clog2(NUM_CH)  mixed sample (minimum width OUT_W+1 when NUM_CH=1).
- busy  out  NUM_CH  per-channel pending-update flag.

## Operation
- Base half-periods H[note] = 166,148,132,124,111,99,88 ticks. Effective half-period P = H >> oct; the minimum is 11.
- Each channel has a counter cnt running 0..2P-1 on ce, then wraps to 0.
- The channel is high when cnt < T: square T=P, 25% T=P>>1, 12.5% T=P>>2. When high, level = (2^OUT_W-1) >> vol; when low, level = 0.
- Rest note, or en=0: level 0 and cnt held at 0.
- Config handshake: a write is accepted when cfg_valid && cfg_ready. cfg_ready = ~busy[cfg_ch].
  - cfg_ch >= NUM_CH: accepted and discarded.
  - An accepted write loads that channel's shadow registers and sets busy.
- Apply rule: shadow values are copied to the active registers, busy is cleared and cnt is set to 0:
  - on the first ce wrap edge (cnt==2P-1 && ce) after the accept edge; or
  - on the clock edge after accept, if the active en=0 or the active note=7.
  - A write accepted on a wrap edge waits for the following wrap.
- Mixer: word = sum of all channel levels, zero-extended. There is no overflow by construction.

## Timing
- Reset values: cnt=0, active and shadow regs all 0 (disabled), busy=0, levels=0, word=0, cfg_ready=1.
- Reset mid-operation clears everything immediately, asynchronously; any pending update is lost.
- Pipeline:
  - cnt is updated at edge N.
  - The channel level is registered from cnt at edge N+1.
  - word is registered from the levels at edge N+2.
  - Config-to-word latency for an idle channel: accept edge A, apply at A+1, level at A+2, word at A+3.
- ce=0: counters freeze; the level and word pipeline still flushes.
- Writes to different channels can be accepted on consecutive cycles. A same-channel write is back-pressured until its apply edge.

## Configuration
- WAVE_GEN_DUTY_EN defined: modes 1 and 2 produce 25% and 12.5% pulses as above.
- WAVE_GEN_DUTY_EN undefined: the duty logic is removed and every mode produces a 50% square. cfg_mode is still accepted and stored.

## Test plan
All scenarios use NUM_CH=2, OUT_W=12, ce=1 every cycle.

- Reset: assert rst mid-run while a channel is busy -> word=0, busy=0, cfg_ready=1 within the same cycle.
- Square: write ch0 note 0, oct 0, mode 0, vol 0, en 1 -> from accept+3, word=4095 for 166 cycles, then 0 for 166, repeating.
- Octave and volume: ch0 note 5, oct 2, vol 1 -> P=24, so word=2047 for 24 cycles and 0 for 24.
- Deferred update: ch0 running note 0; write note 6 at cnt=100 -> busy[0]=1 and cfg_ready low for cfg_ch=0 until the wrap. The old period completes, then the new half-period of 88 starts from cnt=0. No truncated pulse occurs.
- Mixing and duty: ch0 note 0 mode 1, ch1 note 0 mode 0, both vol 0 and enabled on the same cycles -> word=8190 for 83 cycles, 4095 for 83, 0 for 166. Without WAVE_GEN_DUTY_EN: 8190 for 166, then 0 for 166.
- Rest and out-of-range channel: write note 7 to ch1 -> ch1 contributes 0 from accept+3. Write cfg_ch=5 -> accepted in one cycle with no state change.
